accumulate_main: RTL and testbench

In-place prefix-sum (running accumulation) engine over a 1000-entry signed 64-bit array held in a local RAM. The host loads the array through an external memory port and pulses a start strobe. The engine then replaces each element with the running sum from index `init_i` upward and reports the final sum. Afterwards the host reads the results back through the same external port.

---
 rtl/accumulate_pkg.sv | 31 +++
 rtl/accum_ram.sv | 37 +++
 rtl/accumulate_main.sv | 138 +++++++++++++
 tb/tb_accumulate_main.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulate_pkg.sv
// ============================================================================
// Module   : accumulate_pkg
// Brief    : Shared constants and state encoding for the prefix-sum engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package accumulate_pkg;

    localparam int unsigned N_ELEMS = 1000;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement wrapping add; the carry out is intentionally dropped.
    function automatic logic [DATA_W-1:0] wrap_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return a + b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/accum_ram.sv
// ============================================================================
// Module   : accum_ram
// Brief    : DEPTH x DATA_W storage, one synchronous write port and two
//            combinational read ports, no reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_ram #(
    parameter int unsigned DEPTH  = accumulate_pkg::DEPTH,
    parameter int unsigned ADDR_W = accumulate_pkg::ADDR_W,
    parameter int unsigned DATA_W = accumulate_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/accumulate_main.sv
// ============================================================================
// Module   : accumulate_main
// Brief    : In-place running-sum engine over a local RAM with a host port.
//            Optional macro ACCUMULATE_ASSERT_EN compiles in protocol checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accumulate_main #(
    parameter int unsigned N_ELEMS = accumulate_pkg::N_ELEMS,
    parameter int unsigned DEPTH   = accumulate_pkg::DEPTH,
    parameter int unsigned ADDR_W  = accumulate_pkg::ADDR_W,
    parameter int unsigned DATA_W  = accumulate_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     r_enable,
    input  logic        [DATA_W-1:0] init_i,
    input  logic signed [DATA_W-1:0] init_acc,
    output logic                     w_enable,
    output logic signed [DATA_W-1:0] result,
    input  logic                     controlArr,
    input  logic                     controlArrWEnable_a,
    input  logic        [ADDR_W-1:0] controlArrAddr_a,
    input  logic signed [DATA_W-1:0] controlArrWData_a,
    output logic signed [DATA_W-1:0] controlArrRData_a
);

    import accumulate_pkg::*;

    localparam logic [DATA_W-1:0] LIMIT = DATA_W'(N_ELEMS);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  i_q, i_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               done_q, done_d;

    logic               w_eng_we;
    logic [DATA_W-1:0]  w_eng_rdata;
    logic [DATA_W-1:0]  w_sum;
    logic               w_ram_we;
    logic [ADDR_W-1:0]  w_ram_waddr;
    logic [DATA_W-1:0]  w_ram_wdata;
    logic [DATA_W-1:0]  w_ext_rdata;

    assign w_sum = wrap_add(acc_q, w_eng_rdata);

    // The host owns the write port whenever controlArr is high, so engine
    // and host writes can never collide.
    assign w_ram_we    = controlArr ? controlArrWEnable_a : w_eng_we;
    assign w_ram_waddr = controlArr ? controlArrAddr_a    : i_q[ADDR_W-1:0];
    assign w_ram_wdata = controlArr ? controlArrWData_a   : w_sum;

    accum_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (w_ram_we),
        .waddr_i   (w_ram_waddr),
        .wdata_i   (w_ram_wdata),
        .raddr_a_i (controlArrAddr_a),
        .rdata_a_o (w_ext_rdata),
        .raddr_b_i (i_q[ADDR_W-1:0]),
        .rdata_b_o (w_eng_rdata)
    );

    assign controlArrRData_a = w_ext_rdata;
    assign w_enable          = done_q;
    assign result            = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = done_q;
        w_eng_we = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (r_enable) begin
                    state_d = RUN;
                    i_d     = init_i;
                    acc_d   = init_acc;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                // A host-owned RAM freezes the engine completely, termination included.
                if (!controlArr) begin
                    if (i_q >= LIMIT) begin
                        result_d = acc_q;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        w_eng_we = 1'b1;
                        acc_d    = w_sum;
                        i_d      = i_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ACCUMULATE_ASSERT_EN
    a_no_start_in_run: assert property (
        @(posedge clk) disable iff (!rst_n) !(state_q == RUN && r_enable)
    ) else $error("accumulate_main: r_enable asserted during RUN");

    a_no_ext_write_unowned: assert property (
        @(posedge clk) disable iff (!rst_n) !(controlArrWEnable_a && !controlArr)
    ) else $error("accumulate_main: external write enable without RAM ownership");
`endif

endmodule

`default_nettype wire

// File: tb/tb_accumulate_main.sv
// ============================================================================
// Module   : tb_accumulate_main
// Brief    : Directed self-checking bench for accumulate_main with an
//            array-level reference model of the running sum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accumulate_main;

    localparam int N = 1000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               r_enable;
    logic        [63:0] init_i;
    logic signed [63:0] init_acc;
    logic               w_enable;
    logic signed [63:0] result;
    logic               controlArr;
    logic               controlArrWEnable_a;
    logic        [9:0]  controlArrAddr_a;
    logic signed [63:0] controlArrWData_a;
    logic signed [63:0] controlArrRData_a;

    always #5 clk = ~clk;

    accumulate_main dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r_enable            (r_enable),
        .init_i              (init_i),
        .init_acc            (init_acc),
        .w_enable            (w_enable),
        .result              (result),
        .controlArr          (controlArr),
        .controlArrWEnable_a (controlArrWEnable_a),
        .controlArrAddr_a    (controlArrAddr_a),
        .controlArrWData_a   (controlArrWData_a),
        .controlArrRData_a   (controlArrRData_a)
    );

    logic signed [63:0] model_mem   [1024];
    bit                 model_valid [1024];
    logic signed [63:0] exp_result = '0;
    bit                 exp_done   = 1'b0;
    bit                 running    = 1'b0;
    bit                 tb_started = 1'b0;
    int                 checks     = 0;
    int                 failures   = 0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Running sum over the model array; stops after max_steps elements.
    task automatic model_apply(input longint unsigned ii, input longint ia,
                               input int max_steps, output longint acc_o);
        longint          acc = ia;
        longint unsigned k   = ii;
        int              s   = 0;
        while (k < longint'(N) && s < max_steps) begin
            acc          = acc + model_mem[k];
            model_mem[k] = acc;
            k++;
            s++;
        end
        acc_o = acc;
    endtask

    task automatic write_mem(input int addr, input logic signed [63:0] data);
        controlArr          = 1'b1;
        controlArrWEnable_a = 1'b1;
        controlArrAddr_a    = addr[9:0];
        controlArrWData_a   = data;
        @(posedge clk); #1;
        controlArrWEnable_a = 1'b0;
        model_mem[addr]     = data;
        model_valid[addr]   = 1'b1;
    endtask

    task automatic read_lit(input int addr, input logic signed [63:0] exp, input string name);
        controlArrAddr_a = addr[9:0];
        #1;
        chk64(name, controlArrRData_a, exp);
    endtask

    task automatic sweep();
        controlArr = 1'b1;
        for (int a = 0; a < N; a++) begin
            controlArrAddr_a = a[9:0];
            @(posedge clk); #1;
        end
        controlArr       = 1'b0;
        controlArrAddr_a = '0;
    endtask

    task automatic run_engine(input longint unsigned ii, input longint ia,
                              input int stall_at, input int stall_len);
        longint r;
        int     lat;
        int     c;
        controlArr = 1'b0;
        @(posedge clk); #1;
        init_i   = ii;
        init_acc = ia;
        r_enable = 1'b1;
        @(posedge clk); #1;
        r_enable = 1'b0;
        running  = 1'b1;
        exp_done = 1'b0;
        model_apply(ii, ia, 2 * N, r);
        lat = ((ii < longint'(N)) ? (N - int'(ii)) : 0) + 1 + stall_len;
        c   = 0;
        while (!w_enable && c < 3000) begin
            if (stall_len > 0 && c == stall_at) controlArr = 1'b1;
            if (stall_len > 0 && c == stall_at + stall_len) controlArr = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        controlArr = 1'b0;
        if (!w_enable) begin
            failures++;
            $display("FAIL done_timeout: w_enable still 0 after %0d cycles, expected rise at %0d", c, lat);
        end
        chk64("done_latency", 64'(c), 64'(lat));
        running    = 1'b0;
        exp_done   = 1'b1;
        exp_result = r;
    endtask

    // Per-cycle comparison of the observable outputs against the model.
    always @(negedge clk) begin
        if (rst_n && tb_started) begin
            chk64("w_enable", 64'(w_enable), 64'(running ? 1'b0 : exp_done));
            if (!running) begin
                if (exp_done) chk64("result", result, exp_result);
                if (model_valid[controlArrAddr_a])
                    chk64("rdata", controlArrRData_a, model_mem[controlArrAddr_a]);
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        longint tmp;
        for (int a = 0; a < 1024; a++) model_valid[a] = 1'b0;
        rst_n               = 1'b0;
        r_enable            = 1'b0;
        init_i              = '0;
        init_acc            = '0;
        controlArr          = 1'b0;
        controlArrWEnable_a = 1'b0;
        controlArrAddr_a    = '0;
        controlArrWData_a   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk64("reset_w_enable", 64'(w_enable), 64'd0);
        chk64("reset_result", result, 64'd0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        tb_started = 1'b1;

        // Random 32-bit-range signed data, full array from index 0.
        for (int a = 0; a < N; a++) write_mem(a, int'($urandom));
        run_engine(0, 0, -1, 0);
        sweep();

        // All ones with initial accumulator 5.
        for (int a = 0; a < N; a++) write_mem(a, 64'sd1);
        run_engine(0, 5, -1, 0);
        read_lit(0, 64'sd6, "ones_mem0");
        read_lit(999, 64'sd1005, "ones_mem999");
        chk64("ones_result", result, 64'sd1005);

        // Tail start at 998.
        write_mem(998, 64'sd10);
        write_mem(999, 64'sd20);
        run_engine(998, 0, -1, 0);
        read_lit(998, 64'sd10, "tail_mem998");
        read_lit(999, 64'sd30, "tail_mem999");
        read_lit(997, 64'sd1003, "tail_mem997_untouched");
        chk64("tail_result", result, 64'sd30);

        // Start index at the bound: no writes, result is init_acc.
        run_engine(1000, -7, -1, 0);
        chk64("bound_result", result, -64'sd7);
        sweep();

        // Signed overflow wraps.
        write_mem(998, 64'sh7FFF_FFFF_FFFF_FFFF);
        write_mem(999, 64'sd1);
        run_engine(998, 0, -1, 0);
        read_lit(999, 64'sh8000_0000_0000_0000, "wrap_mem999");
        chk64("wrap_result", result, 64'sh8000_0000_0000_0000);

        // Ten-cycle host stall in the middle of a run.
        for (int a = 0; a < N; a++) write_mem(a, 64'(a));
        run_engine(0, 0, 100, 10);
        chk64("stall_result", result, 64'sd499500);
        sweep();

        // Reset in the middle of a run after 50 elements.
        for (int a = 0; a < N; a++) write_mem(a, 64'(a));
        controlArr = 1'b0;
        @(posedge clk); #1;
        init_i   = 0;
        init_acc = 3;
        r_enable = 1'b1;
        @(posedge clk); #1;
        r_enable = 1'b0;
        running  = 1'b1;
        exp_done = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_apply(0, 3, 50, tmp);
        running    = 1'b0;
        exp_result = '0;
        #1;
        chk64("abort_w_enable", 64'(w_enable), 64'd0);
        chk64("abort_result", result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        read_lit(49, 64'sd1228, "abort_mem49");
        read_lit(50, 64'sd50, "abort_mem50_untouched");
        sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
